// File: rtl/qeciphy_gt_pkg.sv
// Shared types and sizing helpers for the multi-lane GT reset sequencer.
package qeciphy_gt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_QPLL_RST  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_GT_RST    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_READY     = 3'd5,
        ST_RX_RST    = 3'd6,
        ST_FAIL      = 3'd7
    } gt_state_e;

    // Width of a counter that can hold the largest of the three limits.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/qeciphy_bit_sync.sv
// Two-flop synchroniser for asynchronous level inputs; resets to zero.
module qeciphy_bit_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/qeciphy_gt_reset_sequencer.sv
// Multi-lane PLL/GT reset and bring-up sequencer with timeouts and bounded retries.
// Optional RX-only recovery on data-valid loss: QECIPHY_RX_DATA_ERR_RESET_EN.
module qeciphy_gt_reset_sequencer
    import qeciphy_gt_pkg::*;
#(
    parameter int NUM_LANES         = 1,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT      = 65536,
    parameter int DONE_TIMEOUT      = 65536,
    parameter int DATA_ERR_CYCLES   = 1024,
    parameter int MAX_RETRIES       = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable_i,
    input  logic                               qplllock_i,
    input  logic                               qpllrefclklost_i,
    input  logic [NUM_LANES-1:0]               txresetdone_i,
    input  logic [NUM_LANES-1:0]               rxresetdone_i,
    input  logic [NUM_LANES-1:0]               rx_data_valid_i,
    output logic                               qpllreset_o,
    output logic [NUM_LANES-1:0]               gttxreset_o,
    output logic [NUM_LANES-1:0]               gtrxreset_o,
    output logic [NUM_LANES-1:0]               txuserrdy_o,
    output logic [NUM_LANES-1:0]               rxuserrdy_o,
    output logic                               tx_ready_o,
    output logic                               rx_ready_o,
    output logic                               error_o,
    output logic [2:0]                         state_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count_o
);

    localparam int TW = timer_width(LOCK_TIMEOUT, DONE_TIMEOUT, RESET_HOLD_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [TW-1:0] HOLD_LIM = TW'(RESET_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LIM = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] DONE_LIM = TW'(DONE_TIMEOUT - 1);

    logic                 lock_s, refclklost_s, pll_lost, done_all, data_err, retry_fire;
    logic [NUM_LANES-1:0] txdone_s, rxdone_s;
    gt_state_e            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic                 rx_only_q, rx_only_d, gt_hold;
    logic                 qpllreset_q, qpllreset_d, tx_ready_q, tx_ready_d;
    logic                 rx_ready_q, rx_ready_d, error_q, error_d;
    logic [NUM_LANES-1:0] gttxreset_q, gttxreset_d, gtrxreset_q, gtrxreset_d;
    logic [NUM_LANES-1:0] txuserrdy_q, txuserrdy_d, rxuserrdy_q, rxuserrdy_d;

    qeciphy_bit_sync #(.WIDTH(2)) u_sync_pll (
        .clk(clk), .rst_n(rst_n),
        .d_i({qpllrefclklost_i, qplllock_i}), .q_o({refclklost_s, lock_s})
    );
    qeciphy_bit_sync #(.WIDTH(2*NUM_LANES)) u_sync_done (
        .clk(clk), .rst_n(rst_n),
        .d_i({txresetdone_i, rxresetdone_i}), .q_o({txdone_s, rxdone_s})
    );

    assign pll_lost = !lock_s || refclklost_s;
    assign done_all = (&txdone_s) && (&rxdone_s);

`ifdef QECIPHY_RX_DATA_ERR_RESET_EN
    localparam int DW = $clog2(DATA_ERR_CYCLES + 1);
    logic [NUM_LANES-1:0] valid_s, lane_err;
    logic [DW-1:0]        err_cnt_q [NUM_LANES];

    qeciphy_bit_sync #(.WIDTH(NUM_LANES)) u_sync_valid (
        .clk(clk), .rst_n(rst_n), .d_i(rx_data_valid_i), .q_o(valid_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) err_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (state_q != ST_READY || valid_s[i])
                    err_cnt_q[i] <= '0;
                else if (err_cnt_q[i] != DW'(DATA_ERR_CYCLES))
                    err_cnt_q[i] <= err_cnt_q[i] + 1'b1;
            end
        end
    end

    // The current low cycle completes the run when the count already holds the other N-1.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++)
            lane_err[i] = !valid_s[i] && (err_cnt_q[i] >= DW'(DATA_ERR_CYCLES - 1));
    end
    assign data_err = |lane_err;
`else
    logic unused_rx_data_valid;
    assign unused_rx_data_valid = ^rx_data_valid_i;
    assign data_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        retry_fire = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else if (pll_lost && (state_q inside {ST_GT_RST, ST_WAIT_DONE, ST_READY, ST_RX_RST})) begin
            state_d = ST_QPLL_RST;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_QPLL_RST;
                ST_QPLL_RST:  if (timer_q == HOLD_LIM) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_s) state_d = ST_GT_RST;
                    else if (timer_q == LOCK_LIM) retry_fire = 1'b1;
                end
                ST_GT_RST:    if (timer_q == HOLD_LIM) state_d = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (done_all) state_d = ST_READY;
                    else if (timer_q == DONE_LIM) begin
`ifdef QECIPHY_RX_DATA_ERR_RESET_EN
                        if (rx_only_q) state_d = ST_RX_RST;
                        else
`endif
                        retry_fire = 1'b1;
                    end
                end
                ST_READY: begin
                    if (data_err) state_d = ST_RX_RST;
                end
`ifdef QECIPHY_RX_DATA_ERR_RESET_EN
                ST_RX_RST:    if (timer_q == HOLD_LIM) state_d = ST_WAIT_DONE;
`endif
                ST_FAIL:      state_d = ST_FAIL;
                default:      state_d = ST_IDLE;
            endcase
            if (retry_fire) begin
                retry_d = retry_q + 1'b1;
                state_d = (retry_d == RW'(MAX_RETRIES)) ? ST_FAIL : ST_QPLL_RST;
            end
        end
        // A fresh enable starts with the full retry budget.
        if (state_d == ST_IDLE || state_d == ST_READY) retry_d = '0;

        rx_only_d = rx_only_q;
        if (state_q == ST_RX_RST && state_d == ST_WAIT_DONE) rx_only_d = 1'b1;
        else if (state_d != ST_WAIT_DONE && state_d != ST_RX_RST) rx_only_d = 1'b0;

        if (state_d != state_q) timer_d = '0;
        else if (&timer_q)      timer_d = timer_q;
        else                    timer_d = timer_q + 1'b1;

        // Outputs are decoded from the next state so they align with state_q.
        gt_hold     = state_d inside {ST_IDLE, ST_QPLL_RST, ST_WAIT_LOCK, ST_GT_RST, ST_FAIL};
        qpllreset_d = state_d inside {ST_IDLE, ST_QPLL_RST, ST_FAIL};
        gttxreset_d = {NUM_LANES{gt_hold}};
        gtrxreset_d = {NUM_LANES{gt_hold || state_d == ST_RX_RST}};
        txuserrdy_d = {NUM_LANES{state_d inside {ST_WAIT_DONE, ST_READY, ST_RX_RST}}};
        rxuserrdy_d = {NUM_LANES{state_d inside {ST_WAIT_DONE, ST_READY}}};
        tx_ready_d  = (state_d == ST_READY) || (state_d == ST_RX_RST) ||
                      (state_d == ST_WAIT_DONE && rx_only_d);
        rx_ready_d  = (state_d == ST_READY);
        error_d     = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            rx_only_q   <= 1'b0;
            qpllreset_q <= 1'b1;
            gttxreset_q <= '1;
            gtrxreset_q <= '1;
            txuserrdy_q <= '0;
            rxuserrdy_q <= '0;
            tx_ready_q  <= 1'b0;
            rx_ready_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            rx_only_q   <= rx_only_d;
            qpllreset_q <= qpllreset_d;
            gttxreset_q <= gttxreset_d;
            gtrxreset_q <= gtrxreset_d;
            txuserrdy_q <= txuserrdy_d;
            rxuserrdy_q <= rxuserrdy_d;
            tx_ready_q  <= tx_ready_d;
            rx_ready_q  <= rx_ready_d;
            error_q     <= error_d;
        end
    end

    assign qpllreset_o   = qpllreset_q;
    assign gttxreset_o   = gttxreset_q;
    assign gtrxreset_o   = gtrxreset_q;
    assign txuserrdy_o   = txuserrdy_q;
    assign rxuserrdy_o   = rxuserrdy_q;
    assign tx_ready_o    = tx_ready_q;
    assign rx_ready_o    = rx_ready_q;
    assign error_o       = error_q;
    assign state_o       = state_q;
    assign retry_count_o = retry_q;

endmodule

// File: tb/tb_qeciphy_gt_reset_sequencer.sv
// Scoreboard bench: the driver queues expected state transitions, a monitor checks each one.
module tb_qeciphy_gt_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable_i = 1'b0;
    logic       qplllock_i = 1'b0;
    logic       qpllrefclklost_i = 1'b0;
    logic [3:0] txresetdone_i = 4'h0;
    logic [3:0] rxresetdone_i = 4'h0;
    logic [3:0] rx_data_valid_i = 4'hF;
    logic       qpllreset_o, tx_ready_o, rx_ready_o, error_o;
    logic [3:0] gttxreset_o, gtrxreset_o, txuserrdy_o, rxuserrdy_o;
    logic [2:0] state_o;
    logic [1:0] retry_count_o;

    always #5 clk = ~clk;

    qeciphy_gt_reset_sequencer #(
        .NUM_LANES(4), .RESET_HOLD_CYCLES(4), .LOCK_TIMEOUT(64),
        .DONE_TIMEOUT(64), .DATA_ERR_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .qplllock_i(qplllock_i), .qpllrefclklost_i(qpllrefclklost_i),
        .txresetdone_i(txresetdone_i), .rxresetdone_i(rxresetdone_i),
        .rx_data_valid_i(rx_data_valid_i),
        .qpllreset_o(qpllreset_o), .gttxreset_o(gttxreset_o), .gtrxreset_o(gtrxreset_o),
        .txuserrdy_o(txuserrdy_o), .rxuserrdy_o(rxuserrdy_o),
        .tx_ready_o(tx_ready_o), .rx_ready_o(rx_ready_o), .error_o(error_o),
        .state_o(state_o), .retry_count_o(retry_count_o)
    );

    typedef struct packed {
        logic       qrst;
        logic [3:0] txr, rxr, txu, rxu;
        logic       tx_rdy, rx_rdy, err;
        logic [1:0] retry;
    } obs_t;

    typedef struct {
        int         dwell;   // expected cycles spent in the previous state, -1 = don't care
        logic [2:0] st;
        obs_t       o;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t ex(int dwell, int st, int retry, bit rxo = 1'b0);
        exp_t e;
        e.dwell = dwell;
        e.st    = 3'(st);
        case (st)
            0:       e.o = '{qrst:1, txr:4'hF, rxr:4'hF, txu:0,    rxu:0,    tx_rdy:0,   rx_rdy:0, err:0, retry:0};
            1:       e.o = '{qrst:1, txr:4'hF, rxr:4'hF, txu:0,    rxu:0,    tx_rdy:0,   rx_rdy:0, err:0, retry:0};
            2, 3:    e.o = '{qrst:0, txr:4'hF, rxr:4'hF, txu:0,    rxu:0,    tx_rdy:0,   rx_rdy:0, err:0, retry:0};
            4:       e.o = '{qrst:0, txr:0,    rxr:0,    txu:4'hF, rxu:4'hF, tx_rdy:rxo, rx_rdy:0, err:0, retry:0};
            5:       e.o = '{qrst:0, txr:0,    rxr:0,    txu:4'hF, rxu:4'hF, tx_rdy:1,   rx_rdy:1, err:0, retry:0};
            6:       e.o = '{qrst:0, txr:0,    rxr:4'hF, txu:4'hF, rxu:0,    tx_rdy:1,   rx_rdy:0, err:0, retry:0};
            default: e.o = '{qrst:1, txr:4'hF, rxr:4'hF, txu:0,    rxu:0,    tx_rdy:0,   rx_rdy:0, err:1, retry:0};
        endcase
        e.o.retry = 2'(retry);
        return e;
    endfunction

    // Monitor: each change of state_o is one DUT response to be matched.
    initial begin
        int   prev_st;
        int   dwell;
        exp_t e;
        obs_t a;
        prev_st = 8;
        dwell   = 0;
        forever begin
            @(negedge clk);
            if (int'(state_o) != prev_st) begin
                a = {qpllreset_o, gttxreset_o, gtrxreset_o, txuserrdy_o, rxuserrdy_o,
                     tx_ready_o, rx_ready_o, error_o, retry_count_o};
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_transition: state %0d -> %0d, required no change", prev_st, state_o);
                end else begin
                    e = sb_q.pop_front();
                    if (state_o !== e.st || a !== e.o) begin
                        errors++;
                        $display("FAIL transition: got state=%0d outs=%h, required state=%0d outs=%h",
                                 state_o, a, e.st, e.o);
                    end
                    if (e.dwell >= 0) begin
                        checks++;
                        if (dwell != e.dwell) begin
                            errors++;
                            $display("FAIL dwell_in_state_%0d: got %0d cycles, required %0d", prev_st, dwell, e.dwell);
                        end
                    end
                end
                prev_st = int'(state_o);
                dwell   = 1;
            end else begin
                dwell++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input exp_t e);
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d transitions still pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        int lat;
        push(ex(-1, 0, 0));
        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Nominal bring-up
        push(ex(-1, 1, 0)); push(ex(4, 2, 0)); push(ex(-1, 3, 0));
        push(ex(4, 4, 0));  push(ex(-1, 5, 0));
        enable_i = 1'b1;
        tick(10);
        qplllock_i = 1'b1;
        tick(20);
        txresetdone_i = 4'hF;
        rxresetdone_i = 4'hF;
        wait_drain(200, "nominal");

        // Reference clock loss in READY
        push(ex(-1, 1, 0)); push(ex(4, 2, 0)); push(ex(-1, 3, 0));
        push(ex(4, 4, 0));  push(ex(-1, 5, 0));
        qpllrefclklost_i = 1'b1;
        lat = 0;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            if (state_o == 3'd1 && lat == 0) lat = i;
        end
        qpllrefclklost_i = 1'b0;
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL pll_loss_latency: state %0d after 3 cycles, required 1", state_o);
        end
        wait_drain(200, "pll_loss");

        // Data-valid loss on lane 1
`ifdef QECIPHY_RX_DATA_ERR_RESET_EN
        push(ex(-1, 6, 0)); push(ex(4, 4, 0, 1'b1)); push(ex(-1, 5, 0));
`endif
        rx_data_valid_i = 4'b1101;
        tick(12);
        rx_data_valid_i = 4'hF;
        tick(20);
`ifdef QECIPHY_RX_DATA_ERR_RESET_EN
        wait_drain(200, "data_err");
`else
        checks++;
        if (state_o != 3'd5) begin
            errors++;
            $display("FAIL data_err_ignored: state %0d, required 5", state_o);
        end
`endif

        // Partial done: lane 2 RX never completes
        push(ex(-1, 0, 0));
        enable_i = 1'b0;
        wait_drain(20, "disable");
        rxresetdone_i = 4'b1011;
        tick(3);
        push(ex(-1, 1, 0)); push(ex(4, 2, 0)); push(ex(-1, 3, 0)); push(ex(4, 4, 0));
        push(ex(64, 1, 1)); push(ex(4, 2, 1)); push(ex(-1, 3, 1)); push(ex(4, 4, 1));
        push(ex(64, 7, 2));
        enable_i = 1'b1;
        wait_drain(400, "partial_done");
        push(ex(-1, 0, 0));
        enable_i = 1'b0;
        wait_drain(20, "fail_exit");

        // Lock never rises
        qplllock_i = 1'b0;
        rxresetdone_i = 4'hF;
        tick(4);
        push(ex(-1, 1, 0)); push(ex(4, 2, 0)); push(ex(64, 1, 1));
        push(ex(4, 2, 1));  push(ex(64, 7, 2));
        enable_i = 1'b1;
        wait_drain(400, "lock_timeout");
        tick(5);
        push(ex(-1, 0, 0));
        enable_i = 1'b0;
        wait_drain(20, "lock_fail_exit");

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
